vx_stream_credit_tx: RTL

- Transmit end of a credit-based stream link: converts a local valid/ready stream into a valid-only stream that carries no ready_out.
- Flow control is by credits returned from the far-end receive buffer, which is CREDITS entries deep.
- Sits between a producer pipeline and a long or registered wire to a remote VX_stream_buffer-style sink.
- Guarantees the sink never overflows, so no combinational ready ever crosses the link.

---
 rtl/vx_stream_credit_tx_pkg.sv | 26 ++
 rtl/vx_stream_credit_tx_credit_counter.sv | 64 ++++++
 rtl/vx_stream_credit_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/vx_stream_credit_tx_pkg.sv
// ---------------------------------------------------------------------------
// vx_stream_credit_tx_pkg
// Shared types and width helpers for the credit-based stream transmitter and
// its credit counter.
//   link_state_e : externally visible link state (credits available / stalled)
//   count_width  : bits needed to hold a count in 0..max_count
//   sum_width    : bits needed for count - 1 + incr without wrapping
// ---------------------------------------------------------------------------
package vx_stream_credit_tx_pkg;

  typedef enum logic {
    ST_HAS_CREDIT = 1'b0,
    ST_STALLED    = 1'b1
  } link_state_e;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  // One extra bit over the wider operand so an over-return from the receiver
  // is always visible as a value above the maximum rather than wrapping.
  function automatic int sum_width(input int cw, input int inc_w);
    return ((cw > inc_w) ? cw : inc_w) + 1;
  endfunction

endpackage

// File: rtl/vx_stream_credit_tx_credit_counter.sv
// ---------------------------------------------------------------------------
// vx_credit_counter
// Saturating credit counter. Resets to MAX, subtracts one on decr_i and adds
// incr_i every cycle. A result above MAX is a receiver protocol error: the
// count is clamped to MAX and a simulation assertion reports it.
// Reusable by receive-side credit generators.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   decr_i        : consume one credit this cycle
//   incr_i        : credits returned this cycle (0 = none)
//   count_o       : registered credit count
//   nonzero_o     : count_o != 0 (registered count only)
//   full_o        : count_o == MAX
// ---------------------------------------------------------------------------
module vx_credit_counter
  import vx_stream_credit_tx_pkg::*;
#(
  parameter int MAX   = 4,
  parameter int INC_W = 1,
  localparam int CW   = count_width(MAX)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             decr_i,
  input  logic [INC_W-1:0] incr_i,
  output logic [CW-1:0]    count_o,
  output logic             nonzero_o,
  output logic             full_o
);

  localparam int SW = sum_width(CW, INC_W);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [SW-1:0] sum;
  logic          overflow;

  always_comb begin
    sum      = SW'(count_q) - SW'(decr_i) + SW'(incr_i);
    overflow = (sum > SW'(MAX));
    count_d  = overflow ? CW'(MAX) : sum[CW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= CW'(MAX);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  assign full_o    = (count_q == CW'(MAX));

  // Receiver returned more credits than were outstanding. Reported as a
  // warning so the clamped behaviour can still be observed afterwards.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!overflow)
        else $warning("vx_credit_counter: credit return above MAX, count clamped");
    end
  end

endmodule

// File: rtl/vx_stream_credit_tx.sv
// ---------------------------------------------------------------------------
// vx_stream_credit_tx
// Transmit end of a credit-based stream link. Turns a local valid/ready
// stream into a valid-only link stream; the far-end receive buffer
// (CREDITS entries) hands credits back on credit_ret, so no ready signal ever
// crosses the link.
//
// Handshake: a beat transfers on a rising clk edge where valid_in && ready_in.
// ready_in depends only on the registered credit count (never on credit_ret
// or valid_in); valid_in may depend on ready_in. The link side has no
// backpressure: every valid_out cycle is exactly one beat.
//
// Ports:
//   clk, reset (async active-low)
//   valid_in / ready_in / data_in : producer stream
//   valid_out / data_out          : link stream (one pulse per beat)
//   credit_ret                    : credits returned this cycle
//   credits                       : current credit count
//   idle                          : all credits home and nothing held
//   state_o                       : link state, 1 = STALLED, 0 = HAS_CREDIT
// ---------------------------------------------------------------------------
module vx_stream_credit_tx
  import vx_stream_credit_tx_pkg::*;
#(
  parameter int DATAW   = 1,
  parameter int CREDITS = 4,
  parameter int RET_W   = 1,
  parameter int OUT_REG = 1,
  localparam int CW     = count_width(CREDITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic [RET_W-1:0] credit_ret,
  output logic [CW-1:0]    credits,
  output logic             idle,
  output logic             state_o
);

  logic        send;
  logic        cnt_nonzero;
  logic        cnt_full;
  link_state_e link_state;

  // The credit is consumed at the send edge, not when the beat leaves the
  // output register, so the count never lags what is already in flight.
  vx_credit_counter #(
    .MAX   (CREDITS),
    .INC_W (RET_W)
  ) u_credit_counter (
    .clk_i     (clk),
    .rst_ni    (reset),
    .decr_i    (send),
    .incr_i    (credit_ret),
    .count_o   (credits),
    .nonzero_o (cnt_nonzero),
    .full_o    (cnt_full)
  );

  assign ready_in = cnt_nonzero;
  assign send     = valid_in && ready_in;

  // HAS_CREDIT / STALLED is fully determined by the count; no extra state.
  assign link_state = cnt_nonzero ? ST_HAS_CREDIT : ST_STALLED;
  assign state_o    = link_state;

  if (OUT_REG != 0) begin : g_out_reg
    logic             valid_q;
    logic             valid_d;
    logic [DATAW-1:0] data_q;
    logic [DATAW-1:0] data_d;

    always_comb begin
      valid_d = send;
      data_d  = data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Payload is qualified by valid_out, so it needs no reset.
    always_ff @(posedge clk) begin
      if (send) begin
        data_q <= data_d;
      end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign idle      = cnt_full && !valid_q;
  end else begin : g_out_comb
    assign valid_out = send;
    assign data_out  = data_in;
    assign idle      = cnt_full;
  end

endmodule
